stage_sequencer: RTL
====================

// Module: stage_sequencer
// PURPOSE
//   Parametrised start/done sequencer for the frame pipeline: pulses each stage's start,
//   waits for its done, grants shared-resource (grid/VGA mux) select to the waiting stage.
//   Stages 0..LOOP_START-1 run once after reset (init, e.g. level load); LOOP_START..N-1 loop,
//   each loop pass aligned to a frame tick from the built-in rate limiter. Adds stuck-stage
//   timeout, enable/pause at stage boundaries, and a frame counter.
// PARAMETERS
//   NUM_STAGES   4        number of stages (2..16)
//   SEL_W        2        width of grant_sel, >= clog2(NUM_STAGES)
//   LOOP_START   1        first looping stage index (0..NUM_STAGES-1)
//   FRAME_CYCLES 1700000  clocks per frame tick (>= 2)
//   CNT_W        21       frame limiter counter width, holds FRAME_CYCLES-1
//   TIMEOUT      65535    max WAIT cycles per stage before forced advance (>= 1)
//   TO_W         16       timeout counter width, holds TIMEOUT
// PORTS
//   clock         in   1           system clock, all logic on posedge
//   reset         in   1           asynchronous, active-low reset
//   enable        in   1           run permission, sampled at stage boundaries
//   stage_done    in   NUM_STAGES  per-stage done; only bit [cur] honoured, only in WAIT
//   stage_start   out  NUM_STAGES  one-hot, 1-cycle start pulse for stage cur
//   grant_sel     out  SEL_W       index of current stage (resource mux select)
//   grant_valid   out  1           1 while in WAIT: grant_sel owns shared resources
//   frame_tick    out  1           1-cycle pulse when limiter counter reaches 0
//   frame_count   out  16          completed loop passes, wraps 0xFFFF->0
//   timeout_err   out  1           sticky: some stage hit TIMEOUT
//   timeout_stage out  SEL_W       index of most recent timed-out stage
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, cur=0, all outputs 0, limiter=FRAME_CYCLES-1, to_cnt=0.
//   Limiter: free-runs always; decrements each clock, at 0 asserts frame_tick and reloads
//     FRAME_CYCLES-1 next clock (tick period exactly FRAME_CYCLES). Runs regardless of enable.
//   States: IDLE, START, WAIT, NEXT, HOLD (registered, Moore outputs).
//   IDLE : enable=1 -> START (cur unchanged). Else stay.
//   START: stage_start[cur]=1 exactly this cycle; to_cnt<=0; -> WAIT.
//   WAIT : grant_valid=1; to_cnt++ per cycle. stage_done[cur]=1 -> NEXT. Else to_cnt==TIMEOUT-1
//          -> timeout_err<=1, timeout_stage<=cur, -> NEXT. Done and timeout same cycle: done
//          wins, no error. Other done bits ignored; done during START/IDLE/HOLD ignored.
//   NEXT : if cur==NUM_STAGES-1: cur<=LOOP_START, frame_count++, -> HOLD.
//          else cur<=cur+1, -> START if enable=1, else IDLE (resumes at cur+1).
//   HOLD : wait for frame_tick; on frame_tick & enable -> START; frame_tick & !enable -> IDLE.
//          frame_tick during NEXT is missed; next pass waits a full frame (documented, intended).
//   Latency: done seen in WAIT cycle t -> next stage_start at t+2 (NEXT, then START).
//   grant_sel=cur in all states; only meaningful with grant_valid. stage_start never overlaps
//     grant_valid. Exactly one start per stage per pass.
//   enable dropped mid-stage: current stage still completes; stop at next boundary.
//   LOOP_START=0: stage 0 also loops; init-only region empty.
//   timeout_err cleared only by reset. Reset mid-WAIT aborts immediately; no done pulse owed.
// TESTING (NUM_STAGES=3, LOOP_START=1, FRAME_CYCLES=50, TIMEOUT=20)
//   Release reset, enable=1, each done 3 clks after its start -> starts 0,1,2 in order, each
//     1 clk wide, grant_sel=0,1,2 with grant_valid in WAIT, frame_count=1 after stage 2 done.
//   Continue -> stage 1 start only on cycle after frame_tick; stage 0 never restarts;
//     consecutive stage-1 starts exactly 50 clks apart; frame_count 2,3,...
//   Hold stage_done[1]=0 -> forced advance after 20 WAIT cycles, timeout_err=1,
//     timeout_stage=1, stage 2 starts; error persists through later passes.
//   Assert stage_done[1] on exactly the 20th WAIT cycle -> no timeout_err.
//   Pulse stage_done[2] while stage 1 waits, and stage_done[cur] during START -> ignored.
//   Drop enable during stage 1 WAIT -> stage 1 finishes, IDLE, no stage 2 start; re-enable ->
//     stage 2 starts 1 clk later. Assert reset mid-WAIT -> all outputs 0 at once, restart at 0.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer
// Start/done sequencer for the frame pipeline. Each stage gets a one-cycle
// start pulse, then owns the shared resources (grant_sel/grant_valid) until
// it reports done or its wait budget runs out. Stages below LOOP_START run
// once after reset. The remaining stages loop, and each pass is aligned to a
// tick from the free-running frame-rate limiter.
module stage_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int SEL_W        = 2,
  parameter int LOOP_START   = 1,
  parameter int FRAME_CYCLES = 1700000,
  parameter int CNT_W        = 21,
  parameter int TIMEOUT      = 65535,
  parameter int TO_W         = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [SEL_W-1:0]      grant_sel,
  output logic                  grant_valid,
  output logic                  frame_tick,
  output logic [15:0]           frame_count,
  output logic                  timeout_err,
  output logic [SEL_W-1:0]      timeout_stage
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_STAGES - 1);
  localparam logic [SEL_W-1:0] LOOP_IDX   = SEL_W'(LOOP_START);
  localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE     = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_ZERO    = TO_W'(0);

  state_t           state_r;
  logic [SEL_W-1:0] cur_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [CNT_W-1:0] lim_r;

  // One-hot vector selecting stage idx (all zero for an out-of-range index).
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      v[i] = (SEL_W'(i) == idx);
    end
    return v;
  endfunction

  // Done bit of the stage idx only; every other done input is ignored.
  function automatic logic cur_done(input logic [NUM_STAGES-1:0] done_vec,
                                    input logic [SEL_W-1:0]      idx);
    return |(done_vec & stage_onehot(idx));
  endfunction

  // The selected stage is always the current one; cur_r is a register.
  assign grant_sel = cur_r;

  // Frame-rate limiter: free-running down-counter, tick is high exactly
  // while the counter sits at zero, so the tick period is FRAME_CYCLES.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lim_r      <= CNT_RELOAD;
      frame_tick <= 1'b0;
    end else if (lim_r == CNT_ZERO) begin
      lim_r      <= CNT_RELOAD;
      frame_tick <= 1'b0;
    end else begin
      lim_r      <= lim_r - CNT_ONE;
      frame_tick <= (lim_r == CNT_ONE);
    end
  end

  // Sequencer FSM with registered Moore outputs: outputs are loaded together
  // with the state they belong to, so stage_start is high only in START and
  // grant_valid only in WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cur_r         <= '0;
      to_cnt_r      <= TO_ZERO;
      stage_start   <= '0;
      grant_valid   <= 1'b0;
      frame_count   <= 16'd0;
      timeout_err   <= 1'b0;
      timeout_stage <= '0;
    end else begin
      stage_start <= '0;
      grant_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r     <= ST_START;
            stage_start <= stage_onehot(cur_r);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          to_cnt_r    <= TO_ZERO;
          state_r     <= ST_WAIT;
          grant_valid <= 1'b1;
        end
        ST_WAIT: begin
          // Done has priority over a timeout landing in the same cycle.
          if (cur_done(stage_done, cur_r)) begin
            state_r <= ST_NEXT;
          end else if (to_cnt_r == TO_LIMIT) begin
            timeout_err   <= 1'b1;
            timeout_stage <= cur_r;
            state_r       <= ST_NEXT;
          end else begin
            to_cnt_r    <= to_cnt_r + TO_ONE;
            grant_valid <= 1'b1;
            state_r     <= ST_WAIT;
          end
        end
        ST_NEXT: begin
          if (cur_r == LAST_IDX) begin
            // End of a pass: rewind to the loop region and wait for a frame.
            cur_r       <= LOOP_IDX;
            frame_count <= frame_count + 16'd1;
            state_r     <= ST_HOLD;
          end else if (enable) begin
            cur_r       <= cur_r + SEL_ONE;
            stage_start <= stage_onehot(cur_r + SEL_ONE);
            state_r     <= ST_START;
          end else begin
            // Paused at a boundary; resumes at the following stage.
            cur_r   <= cur_r + SEL_ONE;
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (frame_tick && enable) begin
            stage_start <= stage_onehot(cur_r);
            state_r     <= ST_START;
          end else if (frame_tick) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cur_r   <= '0;
        end
      endcase
    end
  end

endmodule
